udiv_arbiter: RTL and testbench

UDIV_ARBITER -- requirements
Module: udiv_arbiter

---
 rtl/udiv_pkg.sv | 20 ++
 rtl/rr_pick.sv | 34 +++
 rtl/udiv_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_udiv_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udiv_pkg.sv
// Shared definitions for the divider-arbiter slice: FSM encoding, default
// parameter values and a small index-width helper.
package udiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  localparam int NREQ_DEFAULT    = 4;
  localparam int DWIDTH_DEFAULT  = 8;
  localparam int TIMEOUT_DEFAULT = 64;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: scans requesters starting just after
// last_grant and returns the first active one as one-hot grant plus index.
module rr_pick import udiv_pkg::*; #(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   index
);

  logic          found_s;
  logic [IW-1:0] pos_s;

  // first active requester in rotated order wins
  always_comb begin
    grant   = '0;
    index   = '0;
    found_s = 1'b0;
    pos_s   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      pos_s = IW'((int'(last_grant) + k) % NREQ);
      if (!found_s && req[pos_s]) begin
        grant[pos_s] = 1'b1;
        index        = pos_s;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/udiv_arbiter.sv
// Round-robin arbiter sharing one external divider between NREQ requesters,
// with divide-by-zero bypass and a WAIT-state timeout abort.
module udiv_arbiter import udiv_pkg::*; #(
  parameter int NREQ    = NREQ_DEFAULT,
  parameter int DWIDTH  = DWIDTH_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DWIDTH-1:0] req_dividend,
  input  logic [NREQ*DWIDTH-1:0] req_divisor,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]      rsp_quotient,
  output logic [DWIDTH-1:0]      rsp_remainder,
  output logic                   rsp_err,
  output logic                   rsp_div0,
  output logic                   div_in_valid,
  input  logic                   div_in_ready,
  output logic [DWIDTH-1:0]      div_dividend,
  output logic [DWIDTH-1:0]      div_divisor,
  input  logic                   div_out_valid,
  input  logic [DWIDTH-1:0]      div_quotient,
  input  logic [DWIDTH-1:0]      div_remainder,
  output logic                   busy
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t            state_r, state_nx_s;
  logic [IW-1:0]     last_grant_r, owner_r, pick_idx_s;
  logic [NREQ-1:0]   pick_grant_s;
  logic [DWIDTH-1:0] dvd_a_s [NREQ];
  logic [DWIDTH-1:0] dvs_a_s [NREQ];
  logic [DWIDTH-1:0] sel_dvd_s, sel_dvs_s;
  logic [DWIDTH-1:0] op_a_r, op_b_r, quo_r, rem_r;
  logic [CW-1:0]     wait_cnt_r;
  logic              err_r, div0_r, timeout_s;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (pick_grant_s),
    .index      (pick_idx_s)
  );

  // unpack requester operand buses and select the granted pair
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      dvd_a_s[i] = req_dividend[i*DWIDTH +: DWIDTH];
      dvs_a_s[i] = req_divisor[i*DWIDTH +: DWIDTH];
    end
    sel_dvd_s = dvd_a_s[pick_idx_s];
    sel_dvs_s = dvs_a_s[pick_idx_s];
  end

  assign timeout_s     = (wait_cnt_r == CW'(TIMEOUT - 1));
  assign div_dividend  = op_a_r;
  assign div_divisor   = op_b_r;
  assign rsp_quotient  = quo_r;
  assign rsp_remainder = rem_r;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else if (ce) begin
      state_r <= state_nx_s;
    end else begin
      state_r <= state_r;
    end
  end

  // next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          state_nx_s = (sel_dvs_s == '0) ? ST_RESPOND : ST_ISSUE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (div_in_ready) state_nx_s = ST_WAIT;
        else              state_nx_s = ST_ISSUE;
      end
      ST_WAIT: begin
        if (div_out_valid || timeout_s) state_nx_s = ST_RESPOND;
        else                            state_nx_s = ST_WAIT;
      end
      ST_RESPOND: state_nx_s = ST_IDLE;
      default:    state_nx_s = ST_IDLE;
    endcase
  end

  // outputs decoded from state; strobes qualified by ce so each fires once
  always_comb begin
    req_ready    = '0;
    rsp_valid    = '0;
    div_in_valid = 1'b0;
    busy         = 1'b1;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
        if (ce) req_ready = pick_grant_s;
        else    req_ready = '0;
      end
      ST_ISSUE: div_in_valid = 1'b1;
      ST_WAIT:  div_in_valid = 1'b0;
      ST_RESPOND: begin
        if (ce) rsp_valid = {{(NREQ-1){1'b0}}, 1'b1} << owner_r;
        else    rsp_valid = '0;
      end
      default: busy = 1'b0;
    endcase
    rsp_err  = (rsp_valid != '0) & err_r;
    rsp_div0 = (rsp_valid != '0) & div0_r;
  end

  // datapath: operand capture, wait counter, result and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= IW'(NREQ - 1);
      owner_r      <= '0;
      op_a_r       <= '0;
      op_b_r       <= '0;
      quo_r        <= '0;
      rem_r        <= '0;
      wait_cnt_r   <= '0;
      err_r        <= 1'b0;
      div0_r       <= 1'b0;
    end else if (ce) begin
      case (state_r)
        ST_IDLE: begin
          wait_cnt_r <= '0;
          if (|req_valid) begin
            owner_r <= pick_idx_s;
            err_r   <= 1'b0;
            // zero divisor bypasses the divider, so its operand bus is untouched
            if (sel_dvs_s == '0) begin
              div0_r <= 1'b1;
              quo_r  <= '1;
              rem_r  <= sel_dvd_s;
            end else begin
              div0_r <= 1'b0;
              op_a_r <= sel_dvd_s;
              op_b_r <= sel_dvs_s;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt_r <= '0;
        end
        ST_WAIT: begin
          if (div_out_valid) begin
            quo_r <= div_quotient;
            rem_r <= div_remainder;
          end else if (timeout_s) begin
            quo_r <= '0;
            rem_r <= '0;
            err_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
          end
        end
        ST_RESPOND: begin
          last_grant_r <= owner_r;
        end
        default: begin
          wait_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udiv_arbiter.sv
// Scoreboard bench for udiv_arbiter: directed scenarios plus a randomized
// phase, with a behavioural divider and a transaction-level reference model.
module tb_udiv_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic clk, rst, ce;
  logic [NREQ-1:0]    req_valid, req_ready, rsp_valid;
  logic [NREQ*DW-1:0] req_dividend, req_divisor;
  logic [DW-1:0]      rsp_quotient, rsp_remainder, div_dividend, div_divisor;
  logic [DW-1:0]      div_quotient, div_remainder;
  logic rsp_err, rsp_div0, div_in_valid, div_in_ready, div_out_valid, busy;

  bit div_never, div_kill, stray_req, block_ready, rand_bp;
  int lat_force, ce_mode;
  int n_cmp, n_bad;

  typedef struct {
    int g; logic [DW-1:0] a, b, q, r; bit err, div0; int acc;
  } exp_t;
  exp_t sb[$];
  int last_m;
  int cyc;

  udiv_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_err(rsp_err), .rsp_div0(rsp_div0),
    .div_in_valid(div_in_valid), .div_in_ready(div_in_ready),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_out_valid(div_out_valid), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_grant(input logic [NREQ-1:0] v, input int last);
    int i;
    for (int k = 1; k <= NREQ; k++) begin
      i = (last + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // clock-enable driver
  initial begin
    ce = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ce_mode)
        0:       ce = 1'b1;
        1:       ce = ~ce;
        default: ce = ($urandom % 4) != 0;
      endcase
    end
  end

  // behavioural divider with random latency, backpressure, hang and stray modes
  initial begin
    bit hs, cev, kill_s, stray_s, blk, never_s, rbp, busy_d;
    logic [DW-1:0] a_in, b_in, a_s, b_s;
    int cnt;
    busy_d = 0; cnt = 0; a_s = '0; b_s = '0;
    div_in_ready = 1'b1; div_out_valid = 1'b0; div_quotient = '0; div_remainder = '0;
    forever begin
      @(negedge clk);
      hs = ce && div_in_valid && div_in_ready; cev = ce;
      a_in = div_dividend; b_in = div_divisor;
      kill_s = div_kill; stray_s = stray_req; blk = block_ready;
      never_s = div_never; rbp = rand_bp;
      @(posedge clk); #1;
      if (cev && div_out_valid) div_out_valid = 1'b0;
      if (kill_s) begin
        busy_d = 0; div_out_valid = 1'b0;
      end else if (cev && busy_d) begin
        if (cnt <= 1) begin
          busy_d = 0; div_out_valid = 1'b1;
          div_quotient  = (b_s == '0) ? 8'hFF : a_s / b_s;
          div_remainder = (b_s == '0) ? a_s : a_s % b_s;
        end else cnt--;
      end
      if (hs && !never_s && !kill_s) begin
        busy_d = 1; a_s = a_in; b_s = b_in;
        cnt = (lat_force > 0) ? lat_force : int'($urandom_range(1, 4));
      end
      if (stray_s) begin
        div_out_valid = 1'b1; div_quotient = 8'h5A; div_remainder = 8'hA5;
      end
      div_in_ready = !busy_d && !blk && !(rbp && ($urandom % 3 == 0));
    end
  end

  // monitor: model grants, push expectations, pop and compare responses
  initial begin
    exp_t e;
    int g;
    logic [NREQ-1:0] oh;
    last_m = NREQ - 1; cyc = 0;
    forever begin
      @(negedge clk);
      if (ce) cyc++;
      chk("busy", busy, sb.size() != 0);
      g  = exp_grant(req_valid, last_m);
      oh = '0;
      if (ce && sb.size() == 0 && g >= 0) oh[g] = 1'b1;
      if (req_valid != '0) chk("req_ready", req_ready, oh);
      if (oh != '0 && !rst) begin
        e.g = g; e.a = req_dividend[g*DW +: DW]; e.b = req_divisor[g*DW +: DW];
        e.div0 = (e.b == '0); e.err = !e.div0 && div_never; e.acc = cyc;
        if (e.div0)     begin e.q = 8'hFF; e.r = e.a; end
        else if (e.err) begin e.q = '0; e.r = '0; end
        else            begin e.q = e.a / e.b; e.r = e.a % e.b; end
        sb.push_back(e);
        last_m = g;
      end
      if (div_in_valid) begin
        if (sb.size() == 0) chk("div_in_valid_idle", div_in_valid, 0);
        else begin
          chk("div_dividend", div_dividend, sb[0].a);
          chk("div_divisor", div_divisor, sb[0].b);
          chk("div0_issued", sb[0].div0, 0);
        end
      end
      if (rsp_valid != '0) begin
        if (sb.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
        else begin
          e = sb.pop_front();
          oh = '0; oh[e.g] = 1'b1;
          chk("rsp_valid", rsp_valid, oh);
          chk("rsp_quotient", rsp_quotient, e.q);
          chk("rsp_remainder", rsp_remainder, e.r);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_div0", rsp_div0, e.div0);
          if (e.div0) chk("div0_latency", cyc - e.acc, 1);
          if (e.err)  chk("timeout_latency", cyc - e.acc, TIMEOUT + 2);
        end
      end else if (rsp_err || rsp_div0) begin
        chk("flags_without_rsp", {rsp_err, rsp_div0}, 0);
      end
      if (rst) begin
        sb.delete();
        last_m = NREQ - 1;
      end
    end
  end

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid[i] = 1'b1;
    req_dividend[i*DW +: DW] = a;
    req_divisor[i*DW +: DW]  = b;
  endtask

  task automatic issue(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit got; int n;
    got = 0; n = 0;
    set_req(i, a, b);
    while (!got && n < 200) begin
      @(negedge clk); got = req_valid[i] && req_ready[i] && !rst; n++;
      @(posedge clk); #1;
    end
    req_valid[i] = 1'b0;
    chk("accept_timeout", got, 1);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && n < lim) begin
      @(negedge clk); n++;
    end
    chk("idle_wait_expired", n >= lim, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int order[5];
    int ng, n;
    logic [NREQ-1:0] acc;
    bit seen;
    rst = 1'b1; ce_mode = 0; req_valid = '0; req_dividend = '0; req_divisor = '0;
    div_never = 0; div_kill = 0; stray_req = 0; block_ready = 0; rand_bp = 0; lat_force = 0;
    n_cmp = 0; n_bad = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_div_in_valid", div_in_valid, 0);
    chk("rst_div_operands", {div_dividend, div_divisor}, 0);
    chk("rst_rsp_data", {rsp_quotient, rsp_remainder}, 0);
    chk("rst_flags", {rsp_err, rsp_div0}, 0);
    @(posedge clk); #1;

    // single request
    issue(0, 8'd100, 8'd7);
    wait_idle(100);

    // contention from reset: expected grant order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(30 * i + 17), 8'(i + 2));
    ng = 0; n = 0;
    while (ng < 5 && n < 300) begin
      @(negedge clk); acc = req_valid & req_ready & {NREQ{!rst}}; n++;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && ng < 5) begin
          order[ng] = i; ng++;
          set_req(i, 8'($urandom), 8'($urandom_range(1, 255)));
        end
      end
    end
    req_valid = '0;
    chk("contention_grants", ng, 5);
    for (int k = 0; k < 5; k++) chk("grant_order", order[k], k % NREQ);
    wait_idle(100);

    // divide by zero
    issue(2, 8'd55, 8'd0);
    wait_idle(50);

    // timeout, then normal service
    div_never = 1;
    issue(1, 8'd200, 8'd3);
    wait_idle(TIMEOUT + 40);
    div_never = 0;
    issue(1, 8'd9, 8'd4);
    wait_idle(100);

    // backpressure with ce toggling
    block_ready = 1; ce_mode = 1;
    issue(3, 8'd250, 8'd16);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); chk("bp_div_in_valid", div_in_valid, 1);
      @(posedge clk); #1;
    end
    block_ready = 0;
    wait_idle(100);
    ce_mode = 0;

    // reset while waiting, then a stray divider result
    lat_force = 20;
    issue(2, 8'd40, 8'd6);
    seen = 0; n = 0;
    while (!seen && n < 50) begin
      @(negedge clk); seen = ce && div_in_valid && div_in_ready; n++;
      @(posedge clk); #1;
    end
    chk("wait_reached", seen, 1);
    @(posedge clk); #1;
    rst = 1'b1; div_kill = 1;
    @(posedge clk); #1;
    rst = 1'b0; div_kill = 0; lat_force = 0;
    @(posedge clk); #1;
    stray_req = 1;
    @(posedge clk); #1;
    stray_req = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    @(posedge clk); #1;
    set_req(0, 8'd77, 8'd5);
    set_req(3, 8'd66, 8'd9);
    @(negedge clk);
    chk("post_rst_first_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    issue(3, 8'd66, 8'd9);
    wait_idle(100);

    // randomized traffic with random ce and divider backpressure
    ce_mode = 2; rand_bp = 1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk); acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] || (!req_valid[i] && $urandom % 4 == 0)) begin
          if ($urandom % 2 == 0 && !acc[i]) req_valid[i] = 1'b0;
          else set_req(i, 8'($urandom), ($urandom % 8 == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
        end else if (req_valid[i] && $urandom % 40 == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    wait_idle(200);
    ce_mode = 0; rand_bp = 0;
    repeat (2) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
